// File: rtl/ps2_move_decoder_if.sv
// Signal bundle between the PS/2 pins, the movement decoder and its consumers.
// The decoder takes the slave side; whoever drives the pins and reads the commands takes the master side.
interface ps2_move_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       m_left;
  logic       m_right;
  logic       middle;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  m_left, m_right, middle, rx_byte, rx_valid, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output m_left, m_right, middle, rx_byte, rx_valid, frame_err
  );
endinterface

// File: rtl/ps2_move_decoder.sv
// PS/2 frame receiver and scan-code interpreter producing player movement command levels.
//   state  | meaning
//   IDLE   | waiting for a start bit (data=0 on a ps2_clk fall)
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | capturing the odd-parity bit
//   STOP   | checking stop bit and parity, then back to IDLE
module ps2_move_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 65000
) (
  input  logic              clk,
  input  logic              rst_n,
  ps2_move_decoder_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [7:0]             shift_q, shift_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   par_q, par_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [7:0]             rx_byte_q, rx_byte_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   ext_q, ext_d;
  logic                   brk_q, brk_d;
  logic [3:0]             held_q, held_d;  // {right, left, d, a}
  logic                   m_left_q, m_left_d;
  logic                   m_right_q, m_right_d;
  logic                   middle_q, middle_d;

  logic clk_s, data_s, fall, timeout;

  assign clk_s   = clk_sync_q[SYNC_STAGES-1];
  assign data_s  = data_sync_q[SYNC_STAGES-1];
  assign fall    = clk_prev_q & ~clk_s;
  assign timeout = (state_q != IDLE) && (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      held_q      <= '0;
      m_left_q    <= 1'b0;
      m_right_q   <= 1'b0;
      middle_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      held_q      <= held_d;
      m_left_q    <= m_left_d;
      m_right_q   <= m_right_d;
      middle_q    <= middle_d;
    end
  end

  // A fall in the same cycle as the timeout terminal count keeps the frame alive.
  always_comb begin
    state_d = state_q;
    if (timeout && !fall) begin
      state_d = IDLE;
    end else if (fall) begin
      case (state_q)
        IDLE:    if (!data_s) state_d = DATA;
        DATA:    if (bit_cnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    clk_sync_d  = SYNC_STAGES'({clk_sync_q, bus.ps2_clk});
    data_sync_d = SYNC_STAGES'({data_sync_q, bus.ps2_data});
    clk_prev_d  = clk_s;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    par_d       = par_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    tmo_d       = '0;
    if (timeout && !fall) begin
      frame_err_d = 1'b1;
    end else if (state_q != IDLE && !fall) begin
      tmo_d = tmo_q + 1'b1;
    end
    if (fall) begin
      case (state_q)
        IDLE:   bit_cnt_d = '0;
        DATA: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        PARITY: par_d = data_s;
        STOP: begin
          if (data_s && (^{shift_q, par_q})) begin
            rx_byte_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    ext_d  = ext_q;
    brk_d  = brk_q;
    held_d = held_q;
    if (rx_valid_q) begin
      if (rx_byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (rx_byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        case ({ext_q, rx_byte_q})
          9'h01C:  held_d[0] = ~brk_q;
          9'h023:  held_d[1] = ~brk_q;
          9'h16B:  held_d[2] = ~brk_q;
          9'h174:  held_d[3] = ~brk_q;
          default: ;
        endcase
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
    if (frame_err_d) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end

    // Mapping uses the flags being written this cycle so commands follow rx_valid by one cycle.
    m_left_d  = 1'b0;
    m_right_d = 1'b0;
    middle_d  = 1'b0;
    if (held_d[0] ^ held_d[1]) begin
      m_left_d  = held_d[0];
      m_right_d = held_d[1];
    end else if (held_d[2] ^ held_d[3]) begin
      m_left_d  = held_d[2];
      m_right_d = held_d[3];
      middle_d  = 1'b1;
    end
  end

  assign bus.m_left    = m_left_q;
  assign bus.m_right   = m_right_q;
  assign bus.middle    = middle_q;
  assign bus.rx_byte   = rx_byte_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_ps2_move_decoder.sv
// Self-checking bench for ps2_move_decoder: directed key scenarios, error frames,
// timeout, mid-frame reset and a randomized scan-code stream against a key-state model.
module tb_ps2_move_decoder;
  localparam int SYNC = 2;
  localparam int TMO  = 100;
  localparam int H    = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ps2_move_decoder_if bus_if();

  ps2_move_decoder #(.SYNC_STAGES(SYNC), .TIMEOUT_CYC(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  logic held[4];  // A, D, Left, Right
  logic ext_m, brk_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int key_of(input logic [7:0] b, input logic e);
    if (!e && b == 8'h1C) return 0;
    if (!e && b == 8'h23) return 1;
    if (e && b == 8'h6B)  return 2;
    if (e && b == 8'h74)  return 3;
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) held[i] = 1'b0;
    ext_m = 1'b0;
    brk_m = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int k;
    if (b == 8'hE0) ext_m = 1'b1;
    else if (b == 8'hF0) brk_m = 1'b1;
    else begin
      k = key_of(b, ext_m);
      if (k >= 0) held[k] = !brk_m;
      ext_m = 1'b0;
      brk_m = 1'b0;
    end
  endtask

  task automatic check_outs(input string tag);
    logic l, r, m;
    l = 1'b0; r = 1'b0; m = 1'b0;
    if (held[0] != held[1]) begin
      l = held[0]; r = held[1];
    end else if (held[2] != held[3]) begin
      l = held[2]; r = held[3]; m = 1'b1;
    end
    check({tag, ".m_left"},  bus_if.m_left,  l);
    check({tag, ".m_right"}, bus_if.m_right, r);
    check({tag, ".middle"},  bus_if.middle,  m);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                            input string tag);
    logic [10:0] bits;
    logic        ok;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    ok   = !(bad_par || bad_stop);
    for (int i = 0; i < 11; i++) begin
      bus_if.ps2_data = bits[i];
      repeat (H) @(negedge clk);
      bus_if.ps2_clk = 1'b0;
      if (i == 10) begin
        repeat (SYNC + 1) @(negedge clk);
        check({tag, ".rx_valid"},  bus_if.rx_valid,  ok);
        check({tag, ".frame_err"}, bus_if.frame_err, !ok);
        if (ok) begin
          check({tag, ".rx_byte"}, bus_if.rx_byte, b);
          model_byte(b);
        end else begin
          ext_m = 1'b0;
          brk_m = 1'b0;
        end
        @(negedge clk);
        check({tag, ".rx_valid_end"},  bus_if.rx_valid,  1'b0);
        check({tag, ".frame_err_end"}, bus_if.frame_err, 1'b0);
        check_outs(tag);
        repeat (H - SYNC - 2) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
      bus_if.ps2_clk = 1'b1;
    end
    bus_if.ps2_data = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  task automatic send_trunc(input logic [7:0] b, input int nbits);
    int   k;
    logic seen_valid;
    for (int i = 0; i <= nbits; i++) begin
      bus_if.ps2_data = (i == 0) ? 1'b0 : b[i-1];
      repeat (H) @(negedge clk);
      bus_if.ps2_clk = 1'b0;
      if (i < nbits) begin
        repeat (H) @(negedge clk);
        bus_if.ps2_clk = 1'b1;
      end
    end
    k = 0;
    seen_valid = 1'b0;
    while (k < 4 * TMO && !bus_if.frame_err) begin
      @(negedge clk);
      k++;
      if (bus_if.rx_valid) seen_valid = 1'b1;
      if (k == H) bus_if.ps2_clk = 1'b1;
    end
    check("tmo.latency", k, TMO + SYNC + 1);
    check("tmo.no_valid", seen_valid, 1'b0);
    ext_m = 1'b0;
    brk_m = 1'b0;
    bus_if.ps2_clk  = 1'b1;
    bus_if.ps2_data = 1'b1;
    repeat (H) @(negedge clk);
    check("tmo.err_end", bus_if.frame_err, 1'b0);
    check_outs("tmo");
  endtask

  initial begin
    logic [7:0] b;
    int         r, e;
    bus_if.ps2_clk  = 1'b1;
    bus_if.ps2_data = 1'b1;
    model_clear();
    repeat (4) @(negedge clk);
    check("rst.rx_byte", bus_if.rx_byte, 8'h00);
    check("rst.rx_valid", bus_if.rx_valid, 1'b0);
    check("rst.frame_err", bus_if.frame_err, 1'b0);
    check_outs("rst");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    send_frame(8'h1C, 1'b0, 1'b0, "a_make");
    send_frame(8'hF0, 1'b0, 1'b0, "a_brk0");
    send_frame(8'h1C, 1'b0, 1'b0, "a_brk1");
    send_frame(8'hE0, 1'b0, 1'b0, "r_mk0");
    send_frame(8'h74, 1'b0, 1'b0, "r_mk1");
    send_frame(8'hE0, 1'b0, 1'b0, "r_brk0");
    send_frame(8'hF0, 1'b0, 1'b0, "r_brk1");
    send_frame(8'h74, 1'b0, 1'b0, "r_brk2");

    send_frame(8'h1C, 1'b0, 1'b0, "pri_a");
    send_frame(8'hE0, 1'b0, 1'b0, "pri_r0");
    send_frame(8'h74, 1'b0, 1'b0, "pri_r1");
    send_frame(8'hF0, 1'b0, 1'b0, "pri_abrk0");
    send_frame(8'h1C, 1'b0, 1'b0, "pri_abrk1");
    send_frame(8'hE0, 1'b0, 1'b0, "pri_clr0");
    send_frame(8'hF0, 1'b0, 1'b0, "pri_clr1");
    send_frame(8'h74, 1'b0, 1'b0, "pri_clr2");

    send_frame(8'h1C, 1'b0, 1'b0, "cancel_a");
    send_frame(8'h23, 1'b0, 1'b0, "cancel_d");
    send_frame(8'hF0, 1'b0, 1'b0, "cancel_dbrk0");
    send_frame(8'h23, 1'b0, 1'b0, "cancel_dbrk1");

    send_frame(8'h23, 1'b1, 1'b0, "bad_par");
    send_frame(8'h23, 1'b0, 1'b1, "bad_stop");
    send_frame(8'hF0, 1'b0, 1'b0, "err_pfx0");
    send_frame(8'h1C, 1'b1, 1'b0, "err_pfx1");
    send_frame(8'h1C, 1'b0, 1'b0, "err_pfx2");

    send_trunc(8'h23, 4);
    send_frame(8'h1C, 1'b0, 1'b0, "post_tmo");

    send_frame(8'hF0, 1'b0, 1'b0, "rst_prep0");
    send_frame(8'h1C, 1'b0, 1'b0, "rst_prep1");
    send_frame(8'hE0, 1'b0, 1'b0, "rst_prep2");
    send_frame(8'h74, 1'b0, 1'b0, "rst_prep3");
    check("rst_mid.pre_right", bus_if.m_right, 1'b1);
    bus_if.ps2_data = 1'b0;
    repeat (H) @(negedge clk);
    bus_if.ps2_clk = 1'b0;
    repeat (H) @(negedge clk);
    bus_if.ps2_clk = 1'b1;
    bus_if.ps2_data = 1'b1;
    repeat (H) @(negedge clk);
    bus_if.ps2_clk = 1'b0;
    repeat (H) @(negedge clk);
    bus_if.ps2_clk = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid.m_left", bus_if.m_left, 1'b0);
    check("rst_mid.m_right", bus_if.m_right, 1'b0);
    check("rst_mid.middle", bus_if.middle, 1'b0);
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'hE0, 1'b0, 1'b0, "post_rst0");
    send_frame(8'h6B, 1'b0, 1'b0, "post_rst1");

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    b = 8'hE0;
        2, 3:    b = 8'hF0;
        4:       b = 8'h1C;
        5:       b = 8'h23;
        6:       b = 8'h6B;
        7:       b = 8'h74;
        default: b = 8'($urandom_range(0, 255));
      endcase
      e = $urandom_range(0, 19);
      send_frame(b, e == 0, e == 1, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ps2_move_decoder.md
Name: ps2_move_decoder

Overview:
- Receives PS/2 keyboard frames and turns them into the movement command levels consumed by the player movement controller: m_left, m_right and middle (player-2 select).
- Sits between the board PS/2 pins and the player controller; this is the command producer for that controller.
- Player 1 uses keys A and D. Player 2 uses the Left and Right arrow keys.
- Also exports raw byte, strobe and error flags for debug.

Parameters:
- SYNC_STAGES, 2: synchronizer depth on ps2_clk and ps2_data.
- TIMEOUT_CYC, 65000: clk cycles allowed between PS/2 falling edges inside a frame before the frame is aborted.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- ps2_clk  in  1  raw PS/2 clock, asynchronous to clk
- ps2_data  in  1  raw PS/2 data, asynchronous to clk
- m_left  out  1  move-left command level
- m_right  out  1  move-right command level
- middle  out  1  high when the active command belongs to player 2
- rx_byte  out  8  last correctly received byte
- rx_valid  out  1  one-cycle strobe, rx_byte updated
- frame_err  out  1  one-cycle strobe on parity, stop-bit or timeout error

Behaviour:
- Reset (rst_n=0, async): all outputs 0, FSM in IDLE, all key-held flags and prefix flags cleared, timeout counter 0.
- Input synchronization:
  - Both PS/2 lines pass through SYNC_STAGES flops, each reset to 1.
  - fall = synchronized ps2_clk was 1 last cycle and is 0 now; all sampling happens only on fall.
- Frame FSM. Frame format: start=0, 8 data bits LSB first, odd parity, stop=1.
  - IDLE: on fall with data=0, go to DATA with bit count 0. On fall with data=1 (bad start), stay in IDLE with no error.
  - DATA: shift one bit per fall. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: on fall, check stop=1 and that the XOR of the 8 data bits and the parity bit is 1.
    - Pass: rx_byte loads the byte, rx_valid pulses on the next cycle.
    - Fail: frame_err pulses, the byte is discarded, and the E0/F0 prefix flags are cleared.
    - Either way, return to IDLE.
  - Timeout: in any state other than IDLE, the counter increments each cycle and clears on every fall. When it reaches TIMEOUT_CYC-1, frame_err pulses, prefix flags clear, and the FSM goes to IDLE. A partial frame never produces rx_valid.
- Scan-code interpreter (acts on rx_valid):
  - 0xE0 sets ext. 0xF0 sets brk. Neither changes the key flags.
  - Any other byte is the key code. If brk is clear it is a make, so the key's held flag goes to 1. If brk is set it is a break, so the flag goes to 0. Both ext and brk then clear.
  - Key codes:
    - A: 0x1C with ext=0
    - D: 0x23 with ext=0
    - Left: 0x6B with ext=1
    - Right: 0x74 with ext=1
  - Any other code, including 0x1C/0x23 with ext=1 and 0x6B/0x74 with ext=0, leaves the flags unchanged but still clears ext and brk.
  - Typematic repeats (repeated make codes) are idempotent.
- Output mapping (registered; updates on the cycle after rx_valid):
  - p1_dir is valid when exactly one of A or D is held. p2_dir is valid when exactly one of Left or Right is held.
  - If p1_dir is valid: m_left = A, m_right = D, middle = 0. Player 1 has priority.
  - Else if p2_dir is valid: m_left = Left, m_right = Right, middle = 1.
  - Else all three outputs are 0. Opposite keys held together cancel.
  - m_left and m_right are never both 1.
- Latency:
  - Synchronized stop-bit fall to rx_valid: 1 cycle.
  - rx_valid to m_* change: 1 cycle.
  - Synchronizer delay is SYNC_STAGES cycles on top.
- Reset mid-frame: partial frame lost; the next frame starts clean.

Test Plan:
- Valid frame 0x1C with correct parity -> rx_byte=0x1C, rx_valid pulses once, and one cycle later m_left=1, m_right=0, middle=0.
- Bytes F0,1C after A held -> m_left returns to 0. Then E0,74 -> m_right=1, middle=1. Then E0,F0,74 -> all outputs 0.
- A held, then E0,74 (Right) pressed -> outputs stay at player 1 (m_left=1, middle=0). Then F0,1C -> m_right=1, middle=1.
- A and D both made -> m_left=0 and m_right=0. Then F0,23 -> m_left=1.
- Frame 0x23 with flipped parity bit -> frame_err pulses, no rx_valid, flags unchanged.
- Same frame with stop=0 -> frame_err pulses, no rx_valid, flags unchanged.
- Frame stops after 4 data bits, with TIMEOUT_CYC=100 -> frame_err at cycle 100 after the last edge, FSM in IDLE, and the next valid 0x1C frame decodes correctly.
- rst_n pulled low mid-frame with Right held -> all outputs 0 immediately (async), and the following E0,6B frame gives m_left=1, middle=1.
